// File: rtl/circle_pkg.sv
// Shared types for the parametrised circle/disc drawer: FSM state codes,
// octant/span indices and the signed coordinate width helper.
package circle_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t INIT = 3'd1;
    localparam state_t PLOT = 3'd2;
    localparam state_t STEP = 3'd3;
    localparam state_t DONE = 3'd4;

    typedef logic [2:0] octant_t;
    typedef logic [1:0] span_t;

    // Signed coordinate width with two guard bits so centre +/- radius never wraps
    function automatic int unsigned coord_width(input int unsigned xw,
                                                input int unsigned yw,
                                                input int unsigned rw);
        int unsigned m;
        m = (xw > yw) ? xw : yw;
        if (rw > m) m = rw;
        return m + 2;
    endfunction

endpackage

// File: rtl/circle_clip.sv
// Screen-bounds test for one signed pixel coordinate; also returns the
// coordinate truncated to the vga bus widths.
module circle_clip #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned CW       = 10
) (
    input  logic signed [CW-1:0] x,
    input  logic signed [CW-1:0] y,
    output logic                 in_bounds_c,
    output logic [X_W-1:0]       x_c,
    output logic [Y_W-1:0]       y_c
);

    assign in_bounds_c = !x[CW-1] && !y[CW-1]
                      && ($unsigned(x) < CW'(SCREEN_W))
                      && ($unsigned(y) < CW'(SCREEN_H));
    assign x_c = x[X_W-1:0];
    assign y_c = y[Y_W-1:0];

endmodule

// File: rtl/circle_draw_param.sv
// Midpoint circle engine: outline (8 octant points) or filled disc (4 spans)
// per step, one pixel per cycle, clipped to the screen, into the vga_adapter.
module circle_draw_param
    import circle_pkg::*;
#(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned R_W      = 8,
    parameter int unsigned COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                fill,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [R_W-1:0]      radius,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int unsigned CW  = coord_width(X_W, Y_W, R_W);
    localparam int unsigned CRW = R_W + 3;

    state_t               state, state_n;
    logic                 fill_q, fill_n;
    logic [COLOUR_W-1:0]  colour_q, colour_n;
    logic signed [CW-1:0] cx, cx_n, cy, cy_n;
    logic signed [CW-1:0] ox, ox_n, oy, oy_n, dx, dx_n;
    logic signed [CRW-1:0] crit, crit_n;
    octant_t              oct, oct_n;
    span_t                span, span_n;

    logic signed [CW-1:0] px, py;
    logic                 in_bounds_c;
    logic [X_W-1:0]       clip_x_c;
    logic [Y_W-1:0]       clip_y_c;

    // Next-state and datapath update
    always_comb begin
        state_n  = state;
        fill_n   = fill_q;
        colour_n = colour_q;
        cx_n     = cx;
        cy_n     = cy;
        ox_n     = ox;
        oy_n     = oy;
        crit_n   = crit;
        oct_n    = oct;
        span_n   = span;
        dx_n     = dx;
        case (state)
            IDLE: if (start) state_n = INIT;
            INIT: begin
                fill_n   = fill;
                colour_n = colour;
                cx_n     = CW'(centre_x);
                cy_n     = CW'(centre_y);
                ox_n     = CW'(radius);
                oy_n     = '0;
                crit_n   = CRW'(1) - CRW'(radius);
                oct_n    = '0;
                span_n   = '0;
                dx_n     = -ox_n;
                state_n  = PLOT;
            end
            PLOT: begin
                if (fill_q) begin
                    // Spans 0/1 have half-width ox, spans 2/3 half-width oy
                    if (dx == (span[1] ? oy : ox)) begin
                        if (span == 2'd3) begin
                            state_n = STEP;
                        end else begin
                            span_n = span + 2'd1;
                            dx_n   = -(span_n[1] ? oy : ox);
                        end
                    end else begin
                        dx_n = dx + CW'(1);
                    end
                end else if (oct == 3'd7) begin
                    state_n = STEP;
                end else begin
                    oct_n = oct + 3'd1;
                end
            end
            STEP: begin
                oy_n = oy + CW'(1);
                if (crit[CRW-1] || crit == '0) begin
                    crit_n = crit + (CRW'(oy_n) <<< 1) + CRW'(1);
                end else begin
                    ox_n   = ox - CW'(1);
                    crit_n = crit + ((CRW'(oy_n) - CRW'(ox_n)) <<< 1) + CRW'(1);
                end
                oct_n   = '0;
                span_n  = '0;
                dx_n    = -ox_n;
                state_n = (oy_n <= ox_n) ? PLOT : DONE;
            end
            DONE: if (!start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pixel for the upcoming cycle, so the output registers line up with PLOT
    always_comb begin
        px = cx_n + dx_n;
        py = cy_n;
        if (fill_n) begin
            case (span_n)
                2'd0:    py = cy_n + oy_n;
                2'd1:    py = cy_n - oy_n;
                2'd2:    py = cy_n + ox_n;
                default: py = cy_n - ox_n;
            endcase
        end else begin
            case (oct_n)
                3'd0:    begin px = cx_n + ox_n; py = cy_n + oy_n; end
                3'd1:    begin px = cx_n + oy_n; py = cy_n + ox_n; end
                3'd2:    begin px = cx_n - oy_n; py = cy_n + ox_n; end
                3'd3:    begin px = cx_n - ox_n; py = cy_n + oy_n; end
                3'd4:    begin px = cx_n - ox_n; py = cy_n - oy_n; end
                3'd5:    begin px = cx_n - oy_n; py = cy_n - ox_n; end
                3'd6:    begin px = cx_n + oy_n; py = cy_n - ox_n; end
                default: begin px = cx_n + ox_n; py = cy_n - oy_n; end
            endcase
        end
    end

    circle_clip #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .CW      (CW)
    ) u_clip (
        .x          (px),
        .y          (py),
        .in_bounds_c(in_bounds_c),
        .x_c        (clip_x_c),
        .y_c        (clip_y_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fill_q     <= 1'b0;
            colour_q   <= '0;
            cx         <= '0;
            cy         <= '0;
            ox         <= '0;
            oy         <= '0;
            crit       <= '0;
            oct        <= '0;
            span       <= '0;
            dx         <= '0;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            state      <= state_n;
            fill_q     <= fill_n;
            colour_q   <= colour_n;
            cx         <= cx_n;
            cy         <= cy_n;
            ox         <= ox_n;
            oy         <= oy_n;
            crit       <= crit_n;
            oct        <= oct_n;
            span       <= span_n;
            dx         <= dx_n;
            done       <= (state_n == DONE);
            vga_plot   <= (state_n == PLOT) && in_bounds_c;
            vga_colour <= (state_n == PLOT) ? colour_n : '0;
            if (state_n == PLOT) begin
                vga_x <= clip_x_c;
                vga_y <= clip_y_c;
            end
        end
    end

endmodule
